// File: rtl/gf_mult_serial.sv
// gf_mult_serial: digit-serial GF(2^W) multiplier, out_p = a*b mod (x^W + POLY).
// Latency: W/DIGIT cycles from the accept edge to out_valid; one operation in flight at a time.
// Backpressure: in_ready is low outside IDLE; the result is held in DONE until out_ready.
module gf_mult_serial #(
   parameter int           W     = 4,
   parameter logic [W-1:0] POLY  = W'(4'b0011),
   parameter int           DIGIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_p,
   output logic         busy
);

   // Each digit must cover a whole number of bits of b, so a bad DIGIT stops elaboration.
   if (DIGIT < 1 || (W % DIGIT) != 0) begin : g_bad_digit
      $error("gf_mult_serial: DIGIT must be >= 1 and divide W");
   end

   localparam int NSTEP = W / DIGIT;
   localparam int CW    = $clog2(NSTEP + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  acc_q;
   logic [CW-1:0] count;

   logic [W-1:0]  acc_nxt;
   logic [W-1:0]  b_nxt;

   // DIGIT Horner sub-steps chained in one cycle, walking b MSB-first:
   // acc = acc*x mod P(x), then add a when the current top bit of b is set.
   always_comb begin
      acc_nxt = acc_q;
      b_nxt   = b_q;
      for (int i = 0; i < DIGIT; i++) begin
         acc_nxt = (acc_nxt << 1)
                 ^ (acc_nxt[W-1] ? POLY : '0)
                 ^ (b_nxt[W-1]   ? a_q  : '0);
         b_nxt   = b_nxt << 1;
      end
   end

   // Control FSM and datapath registers; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_p     <= '0;
         busy      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         count     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               // in_ready is high throughout IDLE, so in_valid alone completes the handshake.
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  acc_q    <= '0;
                  count    <= CW'(NSTEP);
                  state    <= S_BUSY;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_BUSY: begin
               acc_q <= acc_nxt;
               b_q   <= b_nxt;
               count <= count - 1'b1;
               // Last digit: publish the fully reduced product straight from the chain.
               if (count == CW'(1)) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  out_p     <= acc_nxt;
               end
            end
            S_DONE: begin
               // out_p keeps its value after the drain; it only matters while out_valid is high.
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gf_mult_serial.sv
// Bench for gf_mult_serial: seven instances covering GF(2^4) and AES GF(2^8) at several digit sizes.
// A reference model (carry-less multiply plus polynomial reduction) and a timing model are checked on every negedge.
// Directed vectors use hand-computed literals; a random phase applies stalls on out_ready.
module tb_gf_mult_serial;

   localparam int NI = 7;

   logic       clk;
   logic       rst;
   logic       in_valid  [NI];
   logic       in_ready  [NI];
   logic [7:0] in_a      [NI];
   logic [7:0] in_b      [NI];
   logic       out_valid [NI];
   logic       out_ready [NI];
   logic [7:0] out_p     [NI];
   logic       busy      [NI];

   int nvec;
   int nfail;
   int cyc;
   bit rand_rdy;

   // Per-instance model state.
   bit         pend   [NI];
   bit         drn    [NI];
   int         t_acc  [NI];
   int         t_free [NI];
   logic [7:0] exp_p  [NI];
   int         issued [NI];
   int         got    [NI];

   function automatic int wid_of(input int k);
      return (k < 3) ? 4 : 8;
   endfunction

   function automatic int dig_of(input int k);
      case (k)
         0, 3:    return 1;
         1, 4:    return 2;
         2, 5:    return 4;
         default: return 8;
      endcase
   endfunction

   function automatic logic [7:0] poly_of(input int k);
      return (k < 3) ? 8'h03 : 8'h1B;
   endfunction

   // Instances 0..2: W=4, POLY=x+1, DIGIT 1/2/4. Instances 3..6: W=8, POLY=0x1B, DIGIT 1/2/4/8.
   for (genvar k = 0; k < NI; k++) begin : g_dut
      localparam int WK = (k < 3) ? 4 : 8;
      localparam int DK = (k == 0 || k == 3) ? 1 :
                          (k == 1 || k == 4) ? 2 :
                          (k == 2 || k == 5) ? 4 : 8;
      localparam logic [WK-1:0] PK = (k < 3) ? WK'(4'h3) : WK'(8'h1B);
      logic [WK-1:0] op;
      gf_mult_serial #(.W(WK), .POLY(PK), .DIGIT(DK)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_a      (in_a[k][WK-1:0]),
         .in_b      (in_b[k][WK-1:0]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_p     (op),
         .busy      (busy[k])
      );
      assign out_p[k] = 8'(op);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Carry-less product of a and b, then long division by x^w + poly.
   function automatic logic [7:0] gf_ref(input int w, input logic [7:0] poly,
                                         input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [15:0] fp;
      p = '0;
      for (int i = 0; i < w; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      fp = (16'd1 << w) | 16'(poly);
      for (int i = 2 * w - 2; i >= w; i--)
         if (p[i]) p = p ^ (fp << (i - w));
      return p[7:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string nm);
      nvec++;
      nfail++;
      $display("FAIL %s: timed out at cycle %0d", nm, cyc);
   endtask

   // Compare process: checks handshake/timing and the product against the model every cycle.
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < NI; k++) begin
            if (pend[k] && !drn[k]) issued[k]--;
            pend[k] = 1'b0;
            drn[k]  = 1'b0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            int  n;
            bit  e_rdy, e_vld, e_busy;
            logic [7:0] msk;
            n = wid_of(k) / dig_of(k);
            msk = (wid_of(k) == 8) ? 8'hFF : 8'h0F;
            if (pend[k] && drn[k] && cyc >= t_free[k]) begin
               pend[k] = 1'b0;
               drn[k]  = 1'b0;
            end
            e_rdy  = !pend[k];
            e_vld  = pend[k] && (cyc >= t_acc[k] + n);
            e_busy = pend[k] && (cyc < t_acc[k] + n);
            chk($sformatf("inst%0d in_ready", k), 32'(in_ready[k]), 32'(e_rdy));
            chk($sformatf("inst%0d out_valid", k), 32'(out_valid[k]), 32'(e_vld));
            chk($sformatf("inst%0d busy", k), 32'(busy[k]), 32'(e_busy));
            if (e_vld) chk($sformatf("inst%0d out_p", k), 32'(out_p[k]), 32'(exp_p[k]));
            if (in_valid[k] && e_rdy) begin
               pend[k]  = 1'b1;
               drn[k]   = 1'b0;
               t_acc[k] = cyc + 1;
               exp_p[k] = gf_ref(wid_of(k), poly_of(k), in_a[k] & msk, in_b[k] & msk);
               issued[k]++;
            end
            if (e_vld && out_ready[k] && !drn[k]) begin
               drn[k]    = 1'b1;
               t_free[k] = cyc + 1;
               got[k]++;
            end
         end
      end
   end

   // Random out_ready stalls for the W=8 instances during the regression phase.
   always @(posedge clk) begin
      #1;
      if (rand_rdy)
         for (int k = 3; k < NI; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
   end

   // Present an operand pair and return one step after the accepting edge.
   task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_a[k] = a;
      in_b[k] = b;
      in_valid[k] = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready[k]) break;
         n++;
         if (n > 300) begin
            timeout_fail($sformatf("inst%0d issue", k));
            break;
         end
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
   endtask

   // Wait for out_valid; lat is the number of negedges waited after issue returned.
   task automatic wait_valid(input int k, output logic [7:0] p, output int lat);
      p = '0;
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (out_valid[k]) begin
            p = out_p[k];
            lat = i;
            return;
         end
      end
      timeout_fail($sformatf("inst%0d wait_valid", k));
   endtask

   // Issue, wait for the result, let it drain (out_ready held high), and check product and latency.
   task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic [7:0] want);
      logic [7:0] p;
      int lat;
      out_ready[k] = 1'b1;
      issue(k, a, b);
      wait_valid(k, p, lat);
      chk($sformatf("inst%0d a=%0h b=%0h product", k, a, b), 32'(p), 32'(want));
      chk($sformatf("inst%0d a=%0h b=%0h latency", k, a, b), 32'(lat), 32'(wid_of(k) / dig_of(k) + 1));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] p;
      int lat;
      int n;
      nvec = 0;
      nfail = 0;
      cyc = 0;
      rand_rdy = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < NI; k++) begin
         in_valid[k] = 1'b0;
         in_a[k] = '0;
         in_b[k] = '0;
         out_ready[k] = 1'b1;
         pend[k] = 1'b0;
         drn[k] = 1'b0;
         issued[k] = 0;
         got[k] = 0;
      end

      // Pin the reference model with hand-computed products.
      chk("model 3*7 GF16", 32'(gf_ref(4, 8'h03, 8'h03, 8'h07)), 32'h09);
      chk("model 8*2 GF16", 32'(gf_ref(4, 8'h03, 8'h08, 8'h02)), 32'h03);
      chk("model F*F GF16", 32'(gf_ref(4, 8'h03, 8'h0F, 8'h0F)), 32'h0A);
      chk("model 57*83 AES", 32'(gf_ref(8, 8'h1B, 8'h57, 8'h83)), 32'hC1);
      chk("model 53*CA AES", 32'(gf_ref(8, 8'h1B, 8'h53, 8'hCA)), 32'h01);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready[0]), 32'd1);
      chk("reset out_valid", 32'(out_valid[0]), 32'd0);
      chk("reset out_p", 32'(out_p[0]), 32'd0);
      chk("reset busy", 32'(busy[0]), 32'd0);

      // Default field, DIGIT=1.
      run_op(0, 8'h3, 8'h7, 8'h9);
      run_op(0, 8'h8, 8'h2, 8'h3);
      run_op(0, 8'hF, 8'hF, 8'hA);

      // Reset in the middle of BUSY discards the operation.
      issue(0, 8'h3, 8'h7);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midbusy reset in_ready", 32'(in_ready[0]), 32'd1);
      chk("midbusy reset out_valid", 32'(out_valid[0]), 32'd0);
      chk("midbusy reset out_p", 32'(out_p[0]), 32'd0);
      chk("midbusy reset busy", 32'(busy[0]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(0, 8'h3, 8'h7, 8'h9);

      // Back-pressure with b=0; in_valid pulses carrying a=F must be ignored.
      out_ready[0] = 1'b0;
      issue(0, 8'h5, 8'h0);
      wait_valid(0, p, lat);
      chk("bp first out_p", 32'(p), 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid[0] = i[0];
         in_a[0] = 8'hF;
         in_b[0] = 8'hF;
         @(negedge clk);
         chk("bp out_valid held", 32'(out_valid[0]), 32'd1);
         chk("bp out_p held", 32'(out_p[0]), 32'h0);
         chk("bp in_ready low", 32'(in_ready[0]), 32'd0);
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp release in_ready", 32'(in_ready[0]), 32'd1);
      chk("bp release out_valid", 32'(out_valid[0]), 32'd0);

      // Digit-serial variants of the same field.
      run_op(1, 8'h8, 8'h2, 8'h3);
      run_op(2, 8'h8, 8'h2, 8'h3);
      run_op(2, 8'hF, 8'hF, 8'hA);

      // AES field.
      run_op(3, 8'h57, 8'h83, 8'hC1);
      run_op(3, 8'h53, 8'hCA, 8'h01);
      run_op(6, 8'h57, 8'h83, 8'hC1);
      run_op(4, 8'h00, 8'hCA, 8'h00);

      // Random regression with out_ready stalls.
      rand_rdy = 1'b1;
      for (int k = 3; k < NI; k++)
         for (int i = 0; i < 250; i++)
            issue(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      n = 0;
      forever begin
         @(negedge clk);
         if (!pend[3] && !pend[4] && !pend[5] && !pend[6]) break;
         n++;
         if (n > 500) begin
            timeout_fail("random drain");
            break;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      for (int k = 3; k < NI; k++) out_ready[k] = 1'b1;

      for (int k = 0; k < NI; k++)
         chk($sformatf("inst%0d results issued vs drained", k), 32'(got[k]), 32'(issued[k]));
      chk("random ops accepted", 32'(issued[3] + issued[4] + issued[5] + issued[6]), 32'd1004);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
